// File: rtl/btn_debounce_pkg.sv
// Shared FSM state type and default timing constants for the push-button debouncer.
package btn_pkg;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    localparam int unsigned DEF_DEBOUNCE_CYCLES   = 270000;
    localparam int unsigned DEF_LONG_PRESS_CYCLES = 13500000;

endpackage

// File: rtl/btn_debounce_sync_2ff.sv
// Two-flop synchronizer with a configurable reset value.
module sync_2ff #(
    parameter int unsigned           WIDTH   = 1,
    parameter logic [WIDTH-1:0]      RST_VAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/btn_debounce.sv
// Push-button debouncer with press/release/long-press strobes and a press counter.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_n,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_press_pulse,
    output logic [7:0] press_count
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int unsigned HW = $clog2(LONG_PRESS_CYCLES) + 1;

    logic          btn_sync;
    logic          raw_pressed;
    state_t        state;
    logic [DW-1:0] db_cnt;
    logic [HW-1:0] hold_cnt;

    sync_2ff #(
        .WIDTH   (1),
        .RST_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_n),
        .q   (btn_sync)
    );

    assign raw_pressed = ~btn_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= RELEASED;
            db_cnt           <= '0;
            hold_cnt         <= '0;
            btn_level        <= 1'b0;
            press_pulse      <= 1'b0;
            release_pulse    <= 1'b0;
            long_press_pulse <= 1'b0;
            press_count      <= '0;
        end else begin
            press_pulse      <= 1'b0;
            release_pulse    <= 1'b0;
            long_press_pulse <= 1'b0;

            // Hold time keeps running through a release glitch so long-press fires once per press.
            if (state == PRESSED || state == RELEASE_WAIT) begin
                if (hold_cnt == HW'(LONG_PRESS_CYCLES - 1))
                    long_press_pulse <= 1'b1;
                if (hold_cnt != HW'(LONG_PRESS_CYCLES))
                    hold_cnt <= hold_cnt + HW'(1);
            end

            case (state)
                RELEASED: begin
                    if (raw_pressed) begin
                        state  <= PRESS_WAIT;
                        db_cnt <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!raw_pressed) begin
                        state <= RELEASED;
                    end else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                        state       <= PRESSED;
                        btn_level   <= 1'b1;
                        press_pulse <= 1'b1;
                        press_count <= press_count + 8'd1;
                        hold_cnt    <= '0;
                    end else begin
                        db_cnt <= db_cnt + DW'(1);
                    end
                end
                PRESSED: begin
                    if (!raw_pressed) begin
                        state  <= RELEASE_WAIT;
                        db_cnt <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (raw_pressed) begin
                        state <= PRESSED;
                    end else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                        state         <= RELEASED;
                        btn_level     <= 1'b0;
                        release_pulse <= 1'b1;
                    end else begin
                        db_cnt <= db_cnt + DW'(1);
                    end
                end
                default: state <= RELEASED;
            endcase
        end
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Scoreboard bench for btn_debounce with short debounce and long-press times.
module tb_btn_debounce;

    localparam int unsigned DC = 4;
    localparam int unsigned LP = 20;

    typedef struct packed {
        logic [1:0] kind;   // 1 press, 2 release, 3 long press
        int         cyc;
        logic       level;
        logic [7:0] cnt;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_n = 1'b1;
    logic       btn_level, press_pulse, release_pulse, long_press_pulse;
    logic [7:0] press_count;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   exp_cnt = 0;
    ev_t  exp_q[$];
    ev_t  obs_q[$];

    btn_debounce #(
        .DEBOUNCE_CYCLES   (DC),
        .LONG_PRESS_CYCLES (LP)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .btn_n            (btn_n),
        .btn_level        (btn_level),
        .press_pulse      (press_pulse),
        .release_pulse    (release_pulse),
        .long_press_pulse (long_press_pulse),
        .press_count      (press_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (press_pulse)      obs_q.push_back('{kind: 2'd1, cyc: cyc, level: btn_level, cnt: press_count});
        if (release_pulse)    obs_q.push_back('{kind: 2'd2, cyc: cyc, level: btn_level, cnt: press_count});
        if (long_press_pulse) obs_q.push_back('{kind: 2'd3, cyc: cyc, level: btn_level, cnt: press_count});
    end

    function automatic ev_t mk(input logic [1:0] kind, input int c, input logic level, input int cnt);
        mk = '{kind: kind, cyc: c, level: level, cnt: cnt[7:0]};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        btn_n = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({btn_level, press_pulse, release_pulse, long_press_pulse} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags got=%b want=0000", {btn_level, press_pulse, release_pulse, long_press_pulse});
        end
        total++;
        if (press_count !== 8'd0) begin
            bad++;
            $display("FAIL reset_count got=%0d want=0", press_count);
        end
        rst = 1'b0;
        exp_cnt = 0;
        repeat (5) @(negedge clk);
        total++;
        if (obs_q.size() != 0) begin
            bad++;
            $display("FAIL reset_idle got=%0d events want=0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_clean();
        int c, r;
        ev_t e, o;
        c = cyc;
        btn_n = 1'b0;
        exp_cnt++;
        exp_q.push_back(mk(2'd1, c + 7, 1'b1, exp_cnt));
        repeat (12) @(negedge clk);
        r = cyc;
        btn_n = 1'b1;
        exp_q.push_back(mk(2'd2, r + 7, 1'b0, exp_cnt));
        repeat (15) @(negedge clk);
        total++;
        if (btn_level !== 1'b0) begin
            bad++;
            $display("FAIL clean_level got=%b want=0", btn_level);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++;
                $display("FAIL clean_event got=none want=kind%0d@%0d", e.kind, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    bad++;
                    $display("FAIL clean_event got=kind%0d@%0d lvl%b cnt%0d want=kind%0d@%0d lvl%b cnt%0d",
                             o.kind, o.cyc, o.level, o.cnt, e.kind, e.cyc, e.level, e.cnt);
                end
            end
        end
        total++;
        if (obs_q.size() != 0) begin
            bad++;
            $display("FAIL clean_extra got=%0d extra events want=0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_bounce();
        int f, r;
        ev_t e, o;
        btn_n = 1'b0;
        repeat (3) @(negedge clk);
        btn_n = 1'b1;
        @(negedge clk);
        f = cyc;
        btn_n = 1'b0;
        exp_cnt++;
        exp_q.push_back(mk(2'd1, f + 7, 1'b1, exp_cnt));
        repeat (10) @(negedge clk);
        r = cyc;
        btn_n = 1'b1;
        exp_q.push_back(mk(2'd2, r + 7, 1'b0, exp_cnt));
        repeat (15) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++;
                $display("FAIL bounce_event got=none want=kind%0d@%0d", e.kind, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    bad++;
                    $display("FAIL bounce_event got=kind%0d@%0d cnt%0d want=kind%0d@%0d cnt%0d",
                             o.kind, o.cyc, o.cnt, e.kind, e.cyc, e.cnt);
                end
            end
        end
        total++;
        if (obs_q.size() != 0) begin
            bad++;
            $display("FAIL bounce_extra got=%0d extra events want=0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_long_press();
        int c;
        ev_t e, o;
        c = cyc;
        btn_n = 1'b0;
        exp_cnt++;
        exp_q.push_back(mk(2'd1, c + 7, 1'b1, exp_cnt));
        exp_q.push_back(mk(2'd3, c + 27, 1'b1, exp_cnt));
        repeat (37) @(negedge clk);
        btn_n = 1'b1;
        exp_q.push_back(mk(2'd2, c + 44, 1'b0, exp_cnt));
        repeat (15) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++;
                $display("FAIL long_event got=none want=kind%0d@%0d", e.kind, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    bad++;
                    $display("FAIL long_event got=kind%0d@%0d cnt%0d want=kind%0d@%0d cnt%0d",
                             o.kind, o.cyc, o.cnt, e.kind, e.cyc, e.cnt);
                end
            end
        end
        total++;
        if (obs_q.size() != 0) begin
            bad++;
            $display("FAIL long_extra got=%0d extra events want=0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_glitch();
        int c;
        logic held;
        ev_t e, o;
        c = cyc;
        btn_n = 1'b0;
        exp_cnt++;
        exp_q.push_back(mk(2'd1, c + 7, 1'b1, exp_cnt));
        repeat (8) @(negedge clk);
        held = 1'b1;
        repeat (4) begin
            held &= btn_level;
            @(negedge clk);
        end
        btn_n = 1'b1;
        repeat (2) @(negedge clk);
        btn_n = 1'b0;
        repeat (4) begin
            held &= btn_level;
            @(negedge clk);
        end
        btn_n = 1'b1;
        repeat (5) begin
            held &= btn_level;
            @(negedge clk);
        end
        total++;
        if (held !== 1'b1) begin
            bad++;
            $display("FAIL glitch_level got=dropped want=held_1");
        end
        exp_q.push_back(mk(2'd2, c + 25, 1'b0, exp_cnt));
        repeat (10) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++;
                $display("FAIL glitch_event got=none want=kind%0d@%0d", e.kind, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    bad++;
                    $display("FAIL glitch_event got=kind%0d@%0d cnt%0d want=kind%0d@%0d cnt%0d",
                             o.kind, o.cyc, o.cnt, e.kind, e.cyc, e.cnt);
                end
            end
        end
        total++;
        if (obs_q.size() != 0) begin
            bad++;
            $display("FAIL glitch_extra got=%0d extra events want=0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_wrap();
        int c, r, n_press, n_rel;
        ev_t e, o;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
        obs_q.delete();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            c = cyc;
            btn_n = 1'b0;
            exp_cnt = (exp_cnt + 1) % 256;
            exp_q.push_back(mk(2'd1, c + 7, 1'b1, exp_cnt));
            repeat (9) @(negedge clk);
            r = cyc;
            btn_n = 1'b1;
            exp_q.push_back(mk(2'd2, r + 7, 1'b0, exp_cnt));
            repeat (9) @(negedge clk);
        end
        repeat (5) @(negedge clk);
        total++;
        if (press_count !== 8'd0) begin
            bad++;
            $display("FAIL wrap_count got=%0d want=0", press_count);
        end
        n_press = 0;
        n_rel = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++;
                $display("FAIL wrap_event got=none want=kind%0d@%0d", e.kind, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.kind == 2'd1) n_press++;
                if (o.kind == 2'd2) n_rel++;
                if (o !== e) begin
                    bad++;
                    $display("FAIL wrap_event got=kind%0d@%0d cnt%0d want=kind%0d@%0d cnt%0d",
                             o.kind, o.cyc, o.cnt, e.kind, e.cyc, e.cnt);
                end
            end
        end
        total++;
        if (n_press != 256 || n_rel != 256 || obs_q.size() != 0) begin
            bad++;
            $display("FAIL wrap_totals got=press%0d rel%0d extra%0d want=press256 rel256 extra0",
                     n_press, n_rel, obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_reset_mid_press();
        int c, d, r;
        ev_t e, o;
        c = cyc;
        btn_n = 1'b0;
        exp_cnt++;
        exp_q.push_back(mk(2'd1, c + 7, 1'b1, exp_cnt));
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({btn_level, press_pulse, release_pulse, long_press_pulse, press_count} !== 12'd0) begin
            bad++;
            $display("FAIL midrst_outputs got=%b_%0d want=0000_0",
                     {btn_level, press_pulse, release_pulse, long_press_pulse}, press_count);
        end
        @(negedge clk);
        d = cyc;
        rst = 1'b0;
        exp_cnt = 1;
        exp_q.push_back(mk(2'd1, d + 7, 1'b1, exp_cnt));
        repeat (12) @(negedge clk);
        r = cyc;
        btn_n = 1'b1;
        exp_q.push_back(mk(2'd2, r + 7, 1'b0, exp_cnt));
        repeat (12) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++;
                $display("FAIL midrst_event got=none want=kind%0d@%0d", e.kind, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    bad++;
                    $display("FAIL midrst_event got=kind%0d@%0d cnt%0d want=kind%0d@%0d cnt%0d",
                             o.kind, o.cyc, o.cnt, e.kind, e.cyc, e.cnt);
                end
            end
        end
        total++;
        if (obs_q.size() != 0) begin
            bad++;
            $display("FAIL midrst_extra got=%0d extra events want=0", obs_q.size());
            obs_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_bounce();
        test_long_press();
        test_glitch();
        test_wrap();
        test_reset_mid_press();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
